// File: rtl/video_pixel_out.sv
// -----------------------------------------------------------------------------
// video_pixel_out
//   Pixel output stage behind the framebuffer. Each pixel byte is colour-mapped
//   either through a CPU-writable 256-entry palette or by direct RGB332
//   expansion. Blanking is then applied and the result drives the RGB DAC.
//   The syncs are delayed so that they stay aligned with the pixel data. The
//   block also counts frames and flags the start of each vertical blank.
//
//   Pipeline (fixed 3-cycle latency for colour, blanking and syncs):
//     S1  register pixel byte and all raster/config flags
//     S2  palette RAM read / RGB332 expansion
//     S3  blank mux -> registered DAC outputs
//
// Ports
//   PxClock            pixel clock; all state on its rising edge
//   Reset_n            synchronous reset, active low
//   PixelIn            pixel byte for the current column/row
//   HBlank, VBlank     blanking flags, same cycle as PixelIn
//   HSync, VSync       sync flags, same cycle as PixelIn
//   BlankBlack         force active area black
//   BlankWhite         force active area white (BlankBlack wins)
//   PalEnable          1: palette lookup, 0: RGB332 expansion
//   PalWrReq           palette write request, held until PalWrAck
//   PalWrAddr          palette entry index
//   PalWrData          {R,G,B} palette entry
//   PalWrAck           one-cycle pulse, one per request
//   Red, Green, Blue   DAC drive
//   HSyncOut, VSyncOut syncs delayed to match RGB
//   FrameStart         one-cycle pulse on the S3 VBlank rising edge
//   FrameCount         frames since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module video_pixel_out #(
    parameter int COLOR_BITS      = 4,
    parameter bit PAL_VBLANK_ONLY = 1'b1
) (
    input  logic                      PxClock,
    input  logic                      Reset_n,
    input  logic [7:0]                PixelIn,
    input  logic                      HBlank,
    input  logic                      VBlank,
    input  logic                      HSync,
    input  logic                      VSync,
    input  logic                      BlankBlack,
    input  logic                      BlankWhite,
    input  logic                      PalEnable,
    input  logic                      PalWrReq,
    input  logic [7:0]                PalWrAddr,
    input  logic [3*COLOR_BITS-1:0]   PalWrData,
    output logic                      PalWrAck,
    output logic [COLOR_BITS-1:0]     Red,
    output logic [COLOR_BITS-1:0]     Green,
    output logic [COLOR_BITS-1:0]     Blue,
    output logic                      HSyncOut,
    output logic                      VSyncOut,
    output logic                      FrameStart,
    output logic [7:0]                FrameCount
);

    localparam int PAL_W = 3 * COLOR_BITS;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // ---------------- S1: input registers ----------------
    logic [7:0] s1_pixel_q;
    logic       s1_hblank_q, s1_vblank_q, s1_hsync_q, s1_vsync_q;
    logic       s1_black_q, s1_white_q, s1_palen_q;

    // On reset the pipeline is flushed to a blanked, sync-idle state. VBlank is
    // flushed high so the first FrameStart needs a real 0->1 edge after reset.
    always_ff @(posedge PxClock) begin
        if (!Reset_n) begin
            s1_pixel_q  <= 8'd0;
            s1_hblank_q <= 1'b1;
            s1_vblank_q <= 1'b1;
            s1_hsync_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_black_q  <= 1'b0;
            s1_white_q  <= 1'b0;
            s1_palen_q  <= 1'b0;
        end else begin
            s1_pixel_q  <= PixelIn;
            s1_hblank_q <= HBlank;
            s1_vblank_q <= VBlank;
            s1_hsync_q  <= HSync;
            s1_vsync_q  <= VSync;
            s1_black_q  <= BlankBlack;
            s1_white_q  <= BlankWhite;
            s1_palen_q  <= PalEnable;
        end
    end

    // ---------------- RGB332 expansion ----------------
    // Each field is replicated MSB-first out to COLOR_BITS (101 -> 1011, 10 -> 1010).
    logic [COLOR_BITS-1:0] exp_r, exp_g, exp_b;

    genvar gi;
    generate
        for (gi = 0; gi < COLOR_BITS; gi++) begin : g_expand
            assign exp_r[gi] = s1_pixel_q[7 - ((COLOR_BITS - 1 - gi) % 3)];
            assign exp_g[gi] = s1_pixel_q[4 - ((COLOR_BITS - 1 - gi) % 3)];
            assign exp_b[gi] = s1_pixel_q[1 - ((COLOR_BITS - 1 - gi) % 2)];
        end
    endgenerate

    // ---------------- Palette RAM and write FSM ----------------
    logic [PAL_W-1:0] pal_mem [256];
    logic [PAL_W-1:0] pal_rd_q;
    logic [0:0]       state_q, state_d;
    logic             pal_we;
    logic             ack_q;

    // Writes are gated by Reset_n, so a reset that lands on a request cannot
    // commit it.
    assign pal_we = Reset_n && (state_q == ST_IDLE) && PalWrReq
                    && (VBlank || !PAL_VBLANK_ONLY);

    // The palette is not reset. Because write and read both use non-blocking
    // assignment, a same-index read returns the old entry.
    always_ff @(posedge PxClock) begin
        if (pal_we) begin
            pal_mem[PalWrAddr] <= PalWrData;
        end
        pal_rd_q <= pal_mem[s1_pixel_q];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pal_we)    state_d = ST_ACK;
            ST_ACK:  if (!PalWrReq) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PxClock) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= pal_we;
        end
    end

    assign PalWrAck = ack_q;

    // ---------------- S2: colour select ----------------
    logic [PAL_W-1:0] s2_rgb332_q;
    logic             s2_palen_q, s2_blank_q, s2_vblank_q, s2_hsync_q, s2_vsync_q;
    logic             s2_black_q, s2_white_q;

    always_ff @(posedge PxClock) begin
        if (!Reset_n) begin
            s2_rgb332_q <= '0;
            s2_palen_q  <= 1'b0;
            s2_blank_q  <= 1'b1;
            s2_vblank_q <= 1'b1;
            s2_hsync_q  <= 1'b0;
            s2_vsync_q  <= 1'b0;
            s2_black_q  <= 1'b0;
            s2_white_q  <= 1'b0;
        end else begin
            s2_rgb332_q <= {exp_r, exp_g, exp_b};
            s2_palen_q  <= s1_palen_q;
            s2_blank_q  <= s1_hblank_q | s1_vblank_q;
            s2_vblank_q <= s1_vblank_q;
            s2_hsync_q  <= s1_hsync_q;
            s2_vsync_q  <= s1_vsync_q;
            s2_black_q  <= s1_black_q;
            s2_white_q  <= s1_white_q;
        end
    end

    // ---------------- S3: blank mux and outputs ----------------
    logic [PAL_W-1:0] s2_color;
    logic [PAL_W-1:0] rgb_d, rgb_q;
    logic             hsync_q, vsync_q, s3_vblank_q, s3_vblank_prev_q;
    logic [7:0]       frame_count_q, frame_count_d;

    assign s2_color = s2_palen_q ? pal_rd_q : s2_rgb332_q;

    always_comb begin
        rgb_d = s2_color;
        if (s2_blank_q || s2_black_q) begin
            rgb_d = '0;
        end else if (s2_white_q) begin
            rgb_d = '1;
        end
    end

    assign FrameStart    = s3_vblank_q && !s3_vblank_prev_q;
    assign frame_count_d = FrameStart ? frame_count_q + 8'd1 : frame_count_q;

    always_ff @(posedge PxClock) begin
        if (!Reset_n) begin
            rgb_q            <= '0;
            hsync_q          <= 1'b0;
            vsync_q          <= 1'b0;
            s3_vblank_q      <= 1'b1;
            s3_vblank_prev_q <= 1'b1;
            frame_count_q    <= 8'd0;
        end else begin
            rgb_q            <= rgb_d;
            hsync_q          <= s2_hsync_q;
            vsync_q          <= s2_vsync_q;
            s3_vblank_q      <= s2_vblank_q;
            s3_vblank_prev_q <= s3_vblank_q;
            frame_count_q    <= frame_count_d;
        end
    end

    assign Red        = rgb_q[PAL_W-1 -: COLOR_BITS];
    assign Green      = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign Blue       = rgb_q[COLOR_BITS-1:0];
    assign HSyncOut   = hsync_q;
    assign VSyncOut   = vsync_q;
    assign FrameCount = frame_count_q;

endmodule
